// File: rtl/servo_pkg.sv
// Shared types for the BLDC commutator: leg state encoding, gate bit positions
// within a channel's phase slice, and the hall-to-leg commutation lookup.
package servo_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DT   = 2'd3
    } leg_state_t;

    localparam int AH = 0;
    localparam int AL = 1;
    localparam int BH = 2;
    localparam int BL = 3;
    localparam int CH = 4;
    localparam int CL = 5;

    localparam logic [1:0] LEG_A = 2'd0;
    localparam logic [1:0] LEG_B = 2'd1;
    localparam logic [1:0] LEG_C = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] hi;
        logic [1:0] lo;
    } legs_t;

    // hall is {Hc,Hb,Ha}; reverse rotation simply swaps the driven legs.
    function automatic legs_t hall_to_legs(input logic [2:0] hall, input logic dir);
        legs_t r;
        r = '{valid: 1'b1, hi: LEG_A, lo: LEG_B};
        case (hall)
            3'b101:  begin r.hi = LEG_A; r.lo = LEG_B; end
            3'b100:  begin r.hi = LEG_A; r.lo = LEG_C; end
            3'b110:  begin r.hi = LEG_B; r.lo = LEG_C; end
            3'b010:  begin r.hi = LEG_B; r.lo = LEG_A; end
            3'b011:  begin r.hi = LEG_C; r.lo = LEG_A; end
            3'b001:  begin r.hi = LEG_C; r.lo = LEG_B; end
            default: r.valid = 1'b0;
        endcase
        if (dir) begin
            r = '{valid: r.valid, hi: r.lo, lo: r.hi};
        end
        return r;
    endfunction

endpackage

// File: rtl/bldc_leg_dt.sv
// One half-bridge leg: OFF/HIGH/LOW/DT state machine with a dead-time counter
// inserted on every direct high<->low flip. Gate outputs are registered.
module bldc_leg_dt
    import servo_pkg::*;
#(
    parameter int DEADTIME = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kill_i,
    input  leg_state_t req_i,
    output logic       hi_o,
    output logic       lo_o
);
    localparam int             CW      = $clog2(DEADTIME + 1);
    localparam logic [CW-1:0]  DT_LOAD = CW'(DEADTIME - 1);
    localparam logic [CW-1:0]  DT_ONE  = CW'(1);

    leg_state_t    state_q;
    logic [CW-1:0] dt_q;
    logic          hi_q;
    logic          lo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= OFF;
            dt_q    <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else if (kill_i) begin
            state_q <= OFF;
            dt_q    <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            case (state_q)
                HIGH: begin
                    if (req_i == LOW) begin
                        state_q <= DT;
                        dt_q    <= DT_LOAD;
                        hi_q    <= 1'b0;
                    end else if (req_i != HIGH) begin
                        state_q <= OFF;
                        hi_q    <= 1'b0;
                    end
                end
                LOW: begin
                    if (req_i == HIGH) begin
                        state_q <= DT;
                        dt_q    <= DT_LOAD;
                        lo_q    <= 1'b0;
                    end else if (req_i != LOW) begin
                        state_q <= OFF;
                        lo_q    <= 1'b0;
                    end
                end
                // DT always runs to completion, then follows whatever is requested now.
                DT: begin
                    if (dt_q == '0) begin
                        state_q <= (req_i == HIGH) ? HIGH : (req_i == LOW) ? LOW : OFF;
                        hi_q    <= (req_i == HIGH);
                        lo_q    <= (req_i == LOW);
                    end else begin
                        dt_q <= dt_q - DT_ONE;
                    end
                end
                default: begin
                    state_q <= (req_i == HIGH) ? HIGH : (req_i == LOW) ? LOW : OFF;
                    hi_q    <= (req_i == HIGH);
                    lo_q    <= (req_i == LOW);
                end
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation for NUM_CH channels: shared edge-aligned PWM counter,
// hall/nfault synchronisers, fault latch and per-leg request generation.
module bldc_commutator
    import servo_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PWM_W    = 12,
    parameter int DEADTIME = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [NUM_CH*PWM_W-1:0] duty,
    input  logic [PWM_W-1:0]        period,
    input  logic [NUM_CH-1:0]       fault_clr,
    input  logic [NUM_CH*3-1:0]     hall,
    input  logic [NUM_CH-1:0]       nfault,
    output logic [NUM_CH*6-1:0]     phase,
    output logic [NUM_CH-1:0]       drv_en,
    output logic [NUM_CH-1:0]       fault,
    output logic [NUM_CH-1:0]       hall_err,
    output logic                    pwm_sync
);
    localparam logic [PWM_W-1:0] CNT_ONE = PWM_W'(1);

    logic [PWM_W-1:0]    cnt_q;
    logic [PWM_W-1:0]    cnt_d;
    logic [PWM_W-1:0]    per_q;
    logic [PWM_W-1:0]    duty_q [NUM_CH];
    logic                wrap;
    logic                pwm_sync_q;
    logic [NUM_CH*3-1:0] hall_s1_q;
    logic [NUM_CH*3-1:0] hall_s2_q;
    logic [NUM_CH-1:0]   nf_s1_q;
    logic [NUM_CH-1:0]   nf_s2_q;
    logic [NUM_CH-1:0]   fault_q;
    logic [NUM_CH-1:0]   fault_d;
    logic [NUM_CH-1:0]   drv_en_q;
    logic [NUM_CH-1:0]   hall_err_q;
    logic [NUM_CH-1:0]   hall_err_d;

    // A zero period parks the counter at 0 and wraps (re-samples) every cycle.
    assign wrap    = (per_q == '0) || (cnt_q == per_q - CNT_ONE);
    assign cnt_d   = wrap ? '0 : cnt_q + CNT_ONE;
    assign fault_d = ~nf_s2_q | (fault_q & ~(fault_clr & nf_s2_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            per_q      <= '0;
            pwm_sync_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) duty_q[c] <= '0;
            hall_s1_q  <= '0;
            hall_s2_q  <= '0;
            nf_s1_q    <= '1;
            nf_s2_q    <= '1;
            fault_q    <= '0;
            drv_en_q   <= '0;
            hall_err_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pwm_sync_q <= wrap;
            if (wrap) begin
                per_q <= period;
                for (int c = 0; c < NUM_CH; c++) duty_q[c] <= duty[c*PWM_W +: PWM_W];
            end
            hall_s1_q  <= hall;
            hall_s2_q  <= hall_s1_q;
            nf_s1_q    <= nfault;
            nf_s2_q    <= nf_s1_q;
            fault_q    <= fault_d;
            drv_en_q   <= enable & ~fault_d;
            hall_err_q <= hall_err_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        legs_t      legs;
        logic       pwm_on;
        logic       kill;
        leg_state_t req [3];

        assign legs          = hall_to_legs(hall_s2_q[3*c +: 3], dir[c]);
        assign pwm_on        = (per_q != '0) && (cnt_q < duty_q[c]);
        // The raw synchronised fault kills the legs in the same cycle the latch sets.
        assign kill          = ~enable[c] | fault_q[c] | ~nf_s2_q[c];
        assign hall_err_d[c] = ~legs.valid;

        always_comb begin
            for (int l = 0; l < 3; l++) begin
                req[l] = OFF;
                if (legs.valid && legs.hi == 2'(l)) begin
                    req[l] = pwm_on ? HIGH : OFF;
                end else if (legs.valid && legs.lo == 2'(l)) begin
                    req[l] = LOW;
                end
            end
        end

        for (genvar l = 0; l < 3; l++) begin : g_leg
            bldc_leg_dt #(
                .DEADTIME(DEADTIME)
            ) u_leg (
                .clk_i (clk),
                .rst_i (reset),
                .kill_i(kill),
                .req_i (req[l]),
                .hi_o  (phase[6*c + AH + 2*l]),
                .lo_o  (phase[6*c + AL + 2*l])
            );
        end
    end

    assign drv_en   = drv_en_q;
    assign fault    = fault_q;
    assign hall_err = hall_err_q;
    assign pwm_sync = pwm_sync_q;

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Parametrised six-step BLDC commutation and PWM engine for NUM_CH motor channels, the next generation of the fixed four-motor drive path in the servo controller. It takes hall sensor states, drives the six gate signals per channel with edge-aligned PWM and dead-time at commutation, and handles DRV8320 fault latching and enable. It sits between the Avalon register file, which supplies duty, period and control, and the gate-driver pins.

## Interface
- NUM_CH, 4, number of motor channels (1..8)
- PWM_W, 12, width of the PWM counter, duty and period
- DEADTIME, 16, dead-time in clk cycles on a leg high↔low flip (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  NUM_CH  per-channel run enable
- dir  in  NUM_CH  per-channel direction; 0 = forward, 1 = reverse
- duty  in  NUM_CH*PWM_W  per-channel high-side on-count; channel c is at [c*PWM_W +: PWM_W]
- period  in  PWM_W  shared PWM period in clk cycles
- fault_clr  in  NUM_CH  single-cycle request to clear a latched fault
- hall  in  NUM_CH*3  asynchronous hall inputs; channel c is {Hc,Hb,Ha} at [3c +: 3]
- nfault  in  NUM_CH  asynchronous DRV8320 fault inputs, active low
- phase  out  NUM_CH*6  gate drives; channel c is [6c +: 6] = {CL,CH,BL,BH,AL,AH} (bit0 = AH)
- drv_en  out  NUM_CH  gate-driver enable, equal to enable & ~fault, registered
- fault  out  NUM_CH  latched fault flag
- hall_err  out  NUM_CH  hall state is invalid (000 or 111); not latched
- pwm_sync  out  1  one-cycle pulse when the PWM counter wraps to 0

## Operation
- **Reset values:** every output is 0. The counter, the latched duty and the latched period are 0. Every leg state machine is in OFF.
- **PWM counter:** the counter runs 0..per_l−1 and then wraps to 0. On each wrap, pwm_sync pulses and per_l and every duty_l are loaded from the inputs, so the new values take effect from the next cycle onward.
  - If per_l = 0, the counter holds at 0, pwm_sync pulses every cycle, and the inputs are re-sampled every cycle.
  - pwm_on = (cnt < duty_l). duty_l ≥ per_l gives 100 % on; duty_l = 0 gives 0 %.
- **Hall inputs:** each hall input passes through a 2-FF synchroniser, then the table below.
- **Forward commutation table (high leg / low leg):** 101: A/B, 100: A/C, 110: B/C, 010: B/A, 011: C/A, 001: C/B.
  - Reverse swaps the high and low legs.
  - 000 or 111 sets hall_err, and all legs of that channel are requested OFF.
- **Leg requests:** the high leg requests HIGH when pwm_on and OFF otherwise. PWM is non-synchronous: the low side is never driven during PWM off-time. The low leg requests LOW. The third leg requests OFF.
- **Leg state machine (per leg):** states are OFF, HIGH, LOW and DT.
  - OFF → HIGH or OFF → LOW happens immediately.
  - HIGH/LOW → OFF happens immediately.
  - HIGH → LOW and LOW → HIGH pass through DT, with both gates off, for exactly DEADTIME cycles.
  - If the request changes during DT, the DT count completes before the leg enters the new request. If the new request is OFF, the leg goes to OFF.
  - Outputs: HIGH gives xH=1, xL=0; LOW gives xH=0, xL=1; OFF and DT give both 0. xH and xL are never both 1.
- **Fault handling:** nfault passes through a 2-FF synchroniser. A synchronised low sets fault, forces that channel's legs to OFF, and clears drv_en.
  - fault_clr clears fault only when the synchronised nfault is high. If fault_clr and an active fault occur in the same cycle, fault stays set.
- **Enable:** enable=0, or fault=1, forces the channel's legs to OFF and drives drv_en low.
- **Leg restart:** when a channel resumes, its legs start from OFF, and the dead-time counters are cleared.

## Timing
- Hall change to phase change: 3 clk (2 synchroniser cycles plus 1 register), plus DEADTIME on a flip.
- nfault low to fault=1 and phase=0: 3 clk. Both are visible in the same cycle.
- enable falling edge to phase=0 and drv_en=0: 1 clk.
- Counter to phase: the register is updated on the edge at which cnt crosses duty_l, so a duty of d gives exactly d cycles high per period.
- Reset asserted mid-operation: all outputs go to 0 asynchronously. After release, the counter restarts at 0.

## Structure
- servo_pkg holds:
  - the leg state enum {OFF, HIGH, LOW, DT};
  - the phase bit-index constants (AH=0 … CL=5);
  - a function hall_to_legs(hall, dir) returning the high/low leg indices plus a valid bit.
- Sub-module bldc_leg_dt holds one leg's state machine and DEADTIME counter. It is instantiated 3*NUM_CH times.
- The top level holds:
  - the shared PWM counter;
  - the synchronisers;
  - the per-channel fault latch and request generation.

## Test plan
- **PWM duty:** NUM_CH=4, period=100, duty0=25, hall0=101, enable0=1 → AH0 is high for 25 of every 100 cycles, BL0 is steady 1, pwm_sync has a 100-cycle period.
- **Dead-time on a flip:** hall0 changes 101→010 with duty at 100 % and DEADTIME=16 → AH0 falls, then 16 cycles with A leg both-off, then AL0=1; BH0 rises immediately after BL0 falls plus 16 cycles.
- **Reverse and invalid hall:** dir0=1 with hall0=100 → CH0 is PWM'd and AL0=1. hall0=111 → hall_err0=1 and phase0=0 within 3 cycles.
- **Fault latch and clear:** nfault2 is pulsed low for 1 cycle → fault2=1 and drv_en2=0 at +3 cycles, and phase2 stays 0. A fault_clr2 pulse while nfault2 is high clears fault2. A fault_clr2 pulse while nfault2 is low leaves fault2 set.
- **Period and duty boundaries:** duty=0 gives AH never on. duty=period+5 gives AH constantly on. period=0 gives no PWM output. A new period written mid-cycle takes effect only after the next wrap.
- **Reset mid-operation:** assert reset during DT → all phase bits go to 0 immediately. After release, the leg starts from OFF and AH is asserted without dead-time.
